bram_rr_arbiter: RTL and testbench

- Shares one single-port, byte-write, 1-cycle-read-latency BRAM among NumReq requesters. Each requester has an OBI-style port (req/gnt, then rvalid/rdata).
- Sits between the core instruction/data ports, debug/DMA masters and the on-chip SRAM macro in the FPGA memory subsystem.
- Arbitration is round-robin. Each response is routed back to the requester that issued it, exactly one cycle after its grant.

---
 rtl/bram_rr_arbiter.sv | 104 ++++++++++
 tb/tb_bram_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write BRAM among NumReq OBI-style requesters.
// Grants are combinational; each response returns to its requester exactly one cycle after its grant.
module bram_rr_arbiter #(
    parameter int NumReq    = 2,
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    localparam int AddrWidth = $clog2(RAM_DEPTH),
    localparam int DataWidth = NB_COL * COL_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    input  logic [NumReq*NB_COL-1:0]    be_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        mem_req_o,
    output logic [AddrWidth-1:0]        mem_addr_o,
    output logic [DataWidth-1:0]        mem_wdata_o,
    output logic [NB_COL-1:0]           mem_bwe_o,
    input  logic [DataWidth-1:0]        mem_rdata_i
);

    localparam int PrioWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PrioWidth-1:0] prio_q, prio_d;
    logic [NumReq-1:0]    rvalid_q, rvalid_d;

    logic                 found;
    logic [PrioWidth-1:0] winner;

    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [NB_COL-1:0]    be_arr    [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
        assign addr_arr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
        assign wdata_arr[gi] = wdata_i[gi*DataWidth +: DataWidth];
        assign be_arr[gi]    = be_i[gi*NB_COL +: NB_COL];
        assign gnt_o[gi]     = found && (winner == PrioWidth'(gi));
    end

    // Search upward from the priority pointer with wrap-around; first hit wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = 0; off < NumReq; off++) begin
            idx = (int'(prio_q) + off) % NumReq;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = PrioWidth'(idx);
            end
        end
    end

    always_comb begin
        int wnext;
        wnext = int'(winner) + 1;
        if (wnext >= NumReq) begin
            wnext = 0;
        end
        prio_d   = found ? PrioWidth'(wnext) : prio_q;
        rvalid_d = gnt_o;
    end

    always_comb begin
        mem_req_o   = |req_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_bwe_o   = '0;
        if (found) begin
            mem_addr_o  = addr_arr[winner];
            mem_wdata_o = wdata_arr[winner];
            mem_bwe_o   = we_i[winner] ? be_arr[winner] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q   <= '0;
            rvalid_q <= '0;
        end else begin
            prio_q   <= prio_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? mem_rdata_i : '0;

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));
    a_rvalid_onehot : assert property (@(posedge clk_i) $onehot0(rvalid_o));
    a_rvalid_follows_gnt : assert property (@(posedge clk_i)
        disable iff (rst_i) !$past(rst_i) |-> (rvalid_o == $past(gnt_o)));
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a write-first byte-write BRAM model behind it.
// Grant/memory-drive outputs are checked each cycle; responses are queued and checked one cycle later.
module tb_bram_rr_arbiter;

    localparam int N     = 2;
    localparam int NC    = 4;
    localparam int CW    = 8;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = NC * CW;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*NC-1:0] be_i;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_req_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [NC-1:0]   mem_bwe_o;
    logic [DW-1:0]   mem_rdata_i;

    bram_rr_arbiter #(
        .NumReq(N), .NB_COL(NC), .COL_WIDTH(CW), .RAM_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_bwe_o(mem_bwe_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 32'hCAFE_0005;
        if (i == 3) return 32'hFFFF_FFFF;
        return {16'hA5A5, 16'(i)};
    endfunction

    // BRAM model: byte-write, write-first, one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (mem_req_o) begin
            w = ram[mem_addr_o];
            for (int b = 0; b < NC; b++)
                if (mem_bwe_o[b]) w[b*CW +: CW] = mem_wdata_o[b*CW +: CW];
            ram[mem_addr_o] <= w;
            mem_rdata_i     <= w;
        end
    end

    typedef struct {
        logic [N-1:0]  rv;
        logic [DW-1:0] rd;
    } resp_t;
    resp_t resp_q[$];

    logic [DW-1:0] shadow [DEPTH];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    logic [NC-1:0] t_be    [N];
    int            exp_prio;
    int            n_checks;
    int            n_fail;
    string         phase;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h, expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic set_port(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NC-1:0] be);
        t_addr[k]  = a;
        t_wdata[k] = d;
        t_be[k]    = be;
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N-1:0] we);
        int            w;
        logic [N-1:0]  egnt;
        logic [NC-1:0] ebwe;
        logic [DW-1:0] word;
        resp_t         r;
        resp_t         got;
        rst_i = rst;
        req_i = req;
        we_i  = we;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = t_addr[k];
            wdata_i[k*DW +: DW] = t_wdata[k];
            be_i[k*NC +: NC]    = t_be[k];
        end
        #1;
        w = -1;
        for (int off = N - 1; off >= 0; off--)
            if (req[(exp_prio + off) % N]) w = (exp_prio + off) % N;
        egnt = '0;
        if (w >= 0) egnt[w] = 1'b1;
        check_val("gnt", 64'(gnt_o), 64'(egnt));
        check_val("mem_req", 64'(mem_req_o), 64'(req != '0));
        r.rv = rst ? '0 : egnt;
        r.rd = '0;
        if (w >= 0) begin
            ebwe = we[w] ? t_be[w] : '0;
            check_val("mem_addr", 64'(mem_addr_o), 64'(t_addr[w]));
            check_val("mem_bwe", 64'(mem_bwe_o), 64'(ebwe));
            if (we[w]) check_val("mem_wdata", 64'(mem_wdata_o), 64'(t_wdata[w]));
            word = shadow[t_addr[w]];
            for (int b = 0; b < NC; b++)
                if (ebwe[b]) word[b*CW +: CW] = t_wdata[w][b*CW +: CW];
            shadow[t_addr[w]] = word;
            if (!rst) r.rd = word;
        end else begin
            check_val("idle_addr", 64'(mem_addr_o), 64'(0));
            check_val("idle_bwe", 64'(mem_bwe_o), 64'(0));
        end
        resp_q.push_back(r);
        if (rst) exp_prio = 0;
        else if (w >= 0) exp_prio = (w + 1) % N;
        @(posedge clk);
        #1;
        got = resp_q.pop_front();
        $display("[%0t] %s rst=%0b req=%b we=%b gnt=%b -> rvalid=%b rdata=%h", $time, phase,
                 rst, req, we, egnt, rvalid_o, rdata_o);
        check_val("rvalid", 64'(rvalid_o), 64'(got.rv));
        check_val("rdata", 64'(rdata_o), 64'(got.rd));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_prio = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        for (int k = 0; k < N; k++) set_port(k, '0, '0, '0);
        rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;

        phase = "reset";
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);

        phase = "single_read";
        set_port(0, AW'(5), '0, '0);
        drive(1'b0, 2'b01, 2'b00);

        phase = "contention";
        drive(1'b1, 2'b00, 2'b00);
        set_port(0, AW'(5), '0, '0);
        set_port(1, AW'(3), '0, '0);
        for (int i = 0; i < 6; i++) drive(1'b0, 2'b11, 2'b00);

        phase = "byte_write";
        set_port(1, AW'(3), 32'h1122_3344, 4'b0101);
        drive(1'b0, 2'b10, 2'b10);
        set_port(0, AW'(3), '0, '0);
        drive(1'b0, 2'b01, 2'b00);

        phase = "read_ignores_be";
        set_port(0, AW'(7), 32'hDEAD_BEEF, 4'b1111);
        drive(1'b0, 2'b01, 2'b00);
        drive(1'b0, 2'b01, 2'b00);

        phase = "idle_hold";
        drive(1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 2'b00);
        set_port(0, AW'(5), '0, '0);
        set_port(1, AW'(7), '0, '0);
        drive(1'b0, 2'b11, 2'b00);

        phase = "reset_mid_op";
        drive(1'b0, 2'b01, 2'b00);
        drive(1'b1, 2'b01, 2'b00);
        drive(1'b0, 2'b11, 2'b00);

        phase = "mixed_rw";
        set_port(0, AW'(9), 32'h0BAD_F00D, 4'b1111);
        set_port(1, AW'(9), 32'h5555_AAAA, 4'b1100);
        drive(1'b0, 2'b11, 2'b11);
        drive(1'b0, 2'b11, 2'b00);

        phase = "random";
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < N; k++)
                set_port(k, AW'($urandom_range(0, 15)), $urandom, NC'($urandom_range(0, 15)));
            drive(1'b0, N'($urandom_range(0, 3)), N'($urandom_range(0, 3)));
        end

        phase = "drain";
        drive(1'b0, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
